// File: rtl/aes_out_arbiter.sv
// Round-robin arbiter sharing the AXI-Stream master output FIFO between several
// AES result producers. A grant is held for a whole packet (up to the requester's
// tlast block); each accepted block is registered into a one-entry output buffer.
// Also produces the processing_done level used downstream to mark TLAST.

module aes_out_arbiter #(
    parameter int unsigned NUM_REQ       = 2,
    parameter int unsigned REQ_IDX_WIDTH = 1,
    parameter int unsigned DATA_WIDTH    = 128
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic [NUM_REQ-1:0]            req_tvalid,
    input  logic [NUM_REQ*DATA_WIDTH-1:0] req_tdata,
    input  logic [NUM_REQ-1:0]            req_tlast,
    output logic [NUM_REQ-1:0]            req_tready,
    output logic                          out_fifo_write_tvalid,
    output logic [DATA_WIDTH-1:0]         out_fifo_data,
    input  logic                          out_fifo_write_tready,
    input  logic                          out_fifo_almost_full,
    output logic                          processing_done,
    output logic [REQ_IDX_WIDTH-1:0]      grant_idx,
    output logic                          busy
);

    // Width needed to select one of NUM_REQ requesters.
    localparam int unsigned SelW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    // Reset grant index so that requester 0 is searched first.
    localparam logic [REQ_IDX_WIDTH-1:0] LastIdx = REQ_IDX_WIDTH'(NUM_REQ - 1);

    typedef enum logic [0:0] {
        StIdle,
        StLock
    } state_e;

    state_e                   state_q, state_d;
    logic [REQ_IDX_WIDTH-1:0] grant_idx_q, grant_idx_d;
    logic                     buf_valid_q, buf_valid_d;
    logic [DATA_WIDTH-1:0]    buf_data_q, buf_data_d;
    logic                     buf_last_q, buf_last_d;
    logic                     done_q, done_d;
    logic                     first_q, first_d;

    logic [SelW-1:0]          gsel;
    logic                     gnt_valid;
    logic                     gnt_last;
    logic [DATA_WIDTH-1:0]    gnt_data;
    logic                     lock_ready;
    logic                     accept;
    logic                     fifo_write;
    logic                     arb_found;
    logic [REQ_IDX_WIDTH-1:0] arb_idx;
    int unsigned              cand;

    assign gsel = grant_idx_q[SelW-1:0];

    // Round-robin search starting one past the last grant, wrapping around.
    always_comb begin
        arb_found = 1'b0;
        arb_idx   = grant_idx_q;
        cand      = 0;
        for (int unsigned off = 1; off <= NUM_REQ; off++) begin
            cand = (32'(grant_idx_q) + off) % NUM_REQ;
            if (!arb_found && req_tvalid[cand[SelW-1:0]]) begin
                arb_found = 1'b1;
                arb_idx   = REQ_IDX_WIDTH'(cand);
            end
        end
    end

    // Route the granted requester's stream signals and drive its ready.
    always_comb begin
        gnt_valid  = 1'b0;
        gnt_last   = 1'b0;
        gnt_data   = '0;
        req_tready = '0;
        // Ready may depend on FIFO ready combinationally, never on req_tvalid.
        lock_ready = (state_q == StLock) && (!buf_valid_q || out_fifo_write_tready);
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            if (gsel == SelW'(i)) begin
                gnt_valid     = req_tvalid[i];
                gnt_last      = req_tlast[i];
                gnt_data      = req_tdata[i*DATA_WIDTH +: DATA_WIDTH];
                req_tready[i] = lock_ready;
            end
        end
        accept     = lock_ready && gnt_valid;
        fifo_write = buf_valid_q && out_fifo_write_tready;
    end

    // Grant FSM next state: almost-full only gates new grants, not a locked packet.
    always_comb begin
        state_d     = state_q;
        grant_idx_d = grant_idx_q;
        first_d     = first_q;
        case (state_q)
            StIdle: begin
                if (arb_found && !out_fifo_almost_full) begin
                    grant_idx_d = arb_idx;
                    first_d     = 1'b1;
                    state_d     = StLock;
                end
            end
            StLock: begin
                if (accept) begin
                    first_d = 1'b0;
                    if (gnt_last) begin
                        state_d = StIdle;
                    end
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // Output buffer next state; a same-cycle drain and load keeps it full.
    always_comb begin
        buf_valid_d = buf_valid_q;
        buf_data_d  = buf_data_q;
        buf_last_d  = buf_last_q;
        if (accept) begin
            buf_valid_d = 1'b1;
            buf_data_d  = gnt_data;
            buf_last_d  = gnt_last;
        end else if (out_fifo_write_tready) begin
            buf_valid_d = 1'b0;
        end
    end

    // Done sets when the tlast block is written; first beat of a new packet clears it.
    always_comb begin
        done_d = done_q;
        if (fifo_write && buf_last_q) begin
            done_d = 1'b1;
        end
        if (accept && first_q) begin
            done_d = 1'b0;
        end
    end

    // State registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= StIdle;
            grant_idx_q <= LastIdx;
            buf_valid_q <= 1'b0;
            buf_data_q  <= '0;
            buf_last_q  <= 1'b0;
            done_q      <= 1'b0;
            first_q     <= 1'b0;
        end else begin
            state_q     <= state_d;
            grant_idx_q <= grant_idx_d;
            buf_valid_q <= buf_valid_d;
            buf_data_q  <= buf_data_d;
            buf_last_q  <= buf_last_d;
            done_q      <= done_d;
            first_q     <= first_d;
        end
    end

    assign out_fifo_write_tvalid = buf_valid_q;
    assign out_fifo_data         = buf_data_q;
    assign processing_done       = done_q;
    assign grant_idx             = grant_idx_q;
    assign busy                  = (state_q == StLock) || buf_valid_q;

endmodule
